// File: rtl/encode_ctrl_pkg.sv
// encode_ctrl_pkg: FSM encoding and sizing constants shared by encode_ctrl and its skid buffer.
// The ERR state only exists when ENCODE_CTRL_TIMEOUT_EN is defined.
package encode_ctrl_pkg;
  localparam int SKID_DEPTH = 2;
  localparam int DS_W = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN
`ifdef ENCODE_CTRL_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;
endpackage

// File: rtl/encode_ctrl_skid.sv
// encode_ctrl_skid: 2-entry FIFO that absorbs the output RAM read latency.
// Ports: clk, rst_n (async active-low), push/din write, pop read,
//        count occupancy (0..2), head = oldest entry (valid when count != 0).
module encode_ctrl_skid
  import encode_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [SKID_DEPTH];
  logic wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem   <= '{default: '0};
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  assign head = mem[rp];
endmodule

// File: rtl/encode_ctrl.sv
// encode_ctrl: accepts a job, pulses enc_start, waits for enc_done, then streams
// OUT_LEN words from the output RAM with a ready/valid handshake.
// Ports: clk, rst_n (async active-low); job_valid/job_ready/job_dataset request;
//        dataset latched index; enc_start/enc_done encoder handshake;
//        cd_rd_addr/cd_rd_data output RAM (1-cycle read latency);
//        out_valid/out_ready/out_data/out_last stream; busy; err (sticky watchdog).
// Optional: define ENCODE_CTRL_TIMEOUT_EN to enable the RUN watchdog and ERR state.
module encode_ctrl
  import encode_ctrl_pkg::*;
#(
  parameter int OUT_DEPTH   = 10,
  parameter int OUT_D_SIZE  = 8,
  parameter int OUT_LEN     = 1007,
  parameter int START_HOLD  = 6,
  parameter int TIMEOUT_CYC = 2 ** 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  job_valid,
  input  logic [DS_W-1:0]       job_dataset,
  output logic                  job_ready,
  output logic [DS_W-1:0]       dataset,
  output logic                  enc_start,
  input  logic                  enc_done,
  output logic [OUT_DEPTH-1:0]  cd_rd_addr,
  input  logic [OUT_D_SIZE-1:0] cd_rd_data,
  output logic                  out_valid,
  output logic [OUT_D_SIZE-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  err
);
  localparam int HW = $clog2(START_HOLD + 1);
  localparam logic [OUT_DEPTH-1:0] LAST = OUT_DEPTH'(OUT_LEN - 1);
  state_t state, state_n;
  logic [HW-1:0] hold_cnt;
  logic issue, issued_all, in_flight, in_last, pop, head_last;
  logic [1:0] count;
  logic [OUT_D_SIZE:0] head;
`ifdef ENCODE_CTRL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd_cnt;
  logic err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= state == S_RUN ? wd_cnt + 1'b1 : '0;
      err_q  <= state_n == S_ERR;
    end
  assign err       = err_q;
  assign job_ready = state == S_IDLE || state == S_ERR;
`else
  assign err       = 1'b0;
  assign job_ready = state == S_IDLE;
`endif
  assign enc_start = state == S_START;
  assign busy      = state != S_IDLE;
  assign out_valid = count != 2'd0;
  assign pop       = out_valid && out_ready;
  assign {head_last, out_data} = head;
  assign out_last  = out_valid && head_last;
  // Count the word being popped this cycle as already gone so a steady
  // out_ready keeps one read issued per cycle without overfilling the skid.
  assign issue = state == S_DRAIN && !issued_all &&
                 (count - {1'b0, pop} + {1'b0, in_flight}) < 2'(SKID_DEPTH);
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (job_valid) state_n = S_START;
      S_START: if (hold_cnt == HW'(START_HOLD - 1)) state_n = S_RUN;
      S_RUN:   if (enc_done) state_n = S_DRAIN;
`ifdef ENCODE_CTRL_TIMEOUT_EN
               else if (wd_cnt == WW'(TIMEOUT_CYC - 1)) state_n = S_ERR;
      S_ERR:   if (job_valid) state_n = S_START;
`endif
      S_DRAIN: if (pop && head_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      dataset    <= '0;
      cd_rd_addr <= '0;
      issued_all <= 1'b0;
      in_flight  <= 1'b0;
      in_last    <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= state == S_START ? hold_cnt + 1'b1 : '0;
      if (job_valid && job_ready) dataset <= job_dataset;
      if (state == S_RUN && enc_done) begin
        cd_rd_addr <= '0;
        issued_all <= 1'b0;
      end else if (issue) begin
        cd_rd_addr <= cd_rd_addr == LAST ? LAST : cd_rd_addr + 1'b1;
        issued_all <= cd_rd_addr == LAST;
      end
      in_flight <= issue;
      in_last   <= issue && cd_rd_addr == LAST;
    end
  encode_ctrl_skid #(.W(OUT_D_SIZE + 1)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_flight),
    .pop   (pop),
    .din   ({in_last, cd_rd_data}),
    .count (count),
    .head  (head)
  );
endmodule

// File: tb/tb_encode_ctrl.sv
// tb_encode_ctrl: table-driven and randomized self-checking bench for encode_ctrl.
module tb_encode_ctrl;
  localparam int OL = 1007;
  localparam int SH = 6;
  localparam int TO = 1000;
  logic clk = 0, rst_n = 1, job_valid = 0, enc_done = 0, out_ready = 0;
  logic [7:0] job_dataset = 0, dataset, out_data, cd_rd_data;
  logic [9:0] cd_rd_addr;
  logic job_ready, enc_start, out_valid, out_last, busy, err;
  int n_chk = 0, n_err = 0;
  int widx = 0;
  logic [7:0] ds_cur = 0;
  typedef struct {
    logic [7:0] ds;
    int dly;
    int mode;
    bit hold;
    bit pulse;
    int rst_at;
    int exp_start;
    int exp_words;
    int exp_lat;
  } rec_t;
  encode_ctrl #(.OUT_DEPTH(10), .OUT_D_SIZE(8), .OUT_LEN(OL), .START_HOLD(SH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_dataset(job_dataset),
    .job_ready(job_ready), .dataset(dataset), .enc_start(enc_start), .enc_done(enc_done),
    .cd_rd_addr(cd_rd_addr), .cd_rd_data(cd_rd_data), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] ew(input logic [7:0] ds, input int a);
    ew = 8'((a * 7) ^ (a >> 3) ^ (int'(ds) * 29));
  endfunction
  always @(posedge clk) cd_rd_data <= ew(dataset, int'(cd_rd_addr));
  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_job(input rec_t r, input string tag);
    int t, st, first, lastpop, acc, ds_bad, addr_bad, stall_at, addr_snap, err_seen;
    bit aborted;
    job_dataset = r.ds;
    job_valid = 1;
    t = 0;
    while (!job_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check({tag, " job_ready"}, job_ready, 1);
    @(posedge clk); #1;
    ds_cur = r.ds; widx = 0; acc = 1; st = 0; first = -1; lastpop = -1;
    ds_bad = 0; addr_bad = 0; stall_at = -1; addr_snap = 0; err_seen = 0; aborted = 0;
    check({tag, " err cleared"}, err, 0);
    check({tag, " dataset"}, dataset, r.ds);
    if (!r.hold) job_valid = 0;
    job_dataset = ~r.ds;
    for (t = 0; t < r.dly + 4 * OL + 200; t++) begin
      enc_done = (t == r.dly) || (r.pulse && t == 2);
      case (r.mode)
        0: out_ready = 1;
        1: out_ready = (t % 2) == 0;
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(stall_at >= 0 && t < stall_at + 50);
      endcase
      if (!busy) break;
      if (enc_start) st++;
      if (err) err_seen++;
      if (dataset != ds_cur) ds_bad++;
      if (int'(cd_rd_addr) > OL - 1) addr_bad++;
      if (job_valid && job_ready) acc++;
      if (out_valid && first < 0) first = t;
      if (out_valid) check({tag, " out_last"}, out_last, widx == OL - 1);
      if (out_valid && out_ready) begin
        check({tag, " word"}, out_data, ew(ds_cur, widx));
        if (out_last) begin
          lastpop = t;
          job_valid = 0;
        end
        widx++;
        if (r.mode == 3 && widx == 200) stall_at = t + 1;
      end
      if (stall_at >= 0 && t == stall_at + 5) addr_snap = int'(cd_rd_addr);
      if (stall_at >= 0 && t == stall_at + 49) check({tag, " addr frozen in stall"}, cd_rd_addr, addr_snap);
      if (r.rst_at >= 0 && widx == r.rst_at) begin
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
    end
    enc_done = 0;
    check({tag, " enc_start cycles"}, st, r.exp_start);
    check({tag, " word count"}, widx, r.exp_words);
    check({tag, " first word latency"}, first - (r.dly + 1), r.exp_lat);
    check({tag, " err low"}, err_seen, 0);
    if (aborted) begin
      rst_n = 0;
      #1;
      check({tag, " rst out_valid"}, out_valid, 0);
      check({tag, " rst out_last"}, out_last, 0);
      check({tag, " rst busy"}, busy, 0);
      check({tag, " rst err"}, err, 0);
      check({tag, " rst enc_start"}, enc_start, 0);
      check({tag, " rst addr"}, cd_rd_addr, 0);
      check({tag, " rst dataset"}, dataset, 0);
      job_valid = 1;
      repeat (2) @(posedge clk);
      #1;
      check({tag, " held in reset"}, busy, 0);
      job_valid = 0;
      rst_n = 1;
      out_ready = 0;
      return;
    end
    check({tag, " finished in budget"}, busy, 0);
    check({tag, " busy drop after last"}, t, lastpop + 1);
    if (r.mode == 0) check({tag, " full throughput span"}, lastpop - first, OL - 1);
    check({tag, " acceptances"}, acc, 1);
    check({tag, " dataset stable"}, ds_bad, 0);
    check({tag, " addr saturates"}, addr_bad, 0);
    out_ready = 0;
  endtask
  initial begin
    #(10 * 90000);
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    rec_t tbl[7];
    rec_t r;
    int t;
    tbl[0] = '{8'h03, 100, 0, 0, 0, -1, SH, OL, 2};
    tbl[1] = '{8'h5a, 20, 1, 0, 0, -1, SH, OL, 2};
    tbl[2] = '{8'h81, 30, 3, 0, 0, -1, SH, OL, 2};
    tbl[3] = '{8'h11, 15, 0, 1, 0, -1, SH, OL, 2};
    tbl[4] = '{8'h22, 40, 0, 0, 1, -1, SH, OL, 2};
    tbl[5] = '{8'h44, 12, 0, 0, 0, 200, SH, 200, 2};
    tbl[6] = '{8'h45, 10, 2, 0, 0, -1, SH, OL, 2};
    #1 rst_n = 0;
    #1;
    check("reset busy", busy, 0);
    check("reset enc_start", enc_start, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_last", out_last, 0);
    check("reset err", err, 0);
    check("reset addr", cd_rd_addr, 0);
    check("reset dataset", dataset, 0);
    check("reset job_ready", job_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 7; i++) run_job(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 3; i++) begin
      r = '{8'($urandom), int'($urandom_range(SH, 80)), int'($urandom_range(0, 3)), 0, 0, -1, SH, OL, 2};
      run_job(r, $sformatf("rand%0d", i));
    end
`ifdef ENCODE_CTRL_TIMEOUT_EN
    job_dataset = 8'h66;
    job_valid = 1;
    @(posedge clk); #1;
    job_valid = 0;
    t = 0;
    while (!err && t < SH + TO + 20) begin
      @(posedge clk); #1; t++;
    end
    check("timeout err cycle", t, SH + TO);
    check("timeout err", err, 1);
    check("timeout job_ready", job_ready, 1);
    check("timeout busy", busy, 1);
    r = '{8'h77, 25, 0, 0, 0, -1, SH, OL, 2};
    run_job(r, "after_err");
`else
    r = '{8'h77, 1200, 0, 0, 0, -1, SH, OL, 2};
    run_job(r, "long_wait");
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/encode_ctrl.md
ENCODE_CTRL -- requirements
Module: encode_ctrl

Interface
REQ-001 SHALL have parameters: OUT_DEPTH, default 10, output-RAM address width; OUT_D_SIZE, default 8, output word width; OUT_LEN, default 1007, output words per job (1..2^OUT_DEPTH); START_HOLD, default 6, enc_start high cycles; TIMEOUT_CYC, default 2^20, watchdog limit.
REQ-002 SHALL have ports, one clock, async active-low reset, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  job request
- job_dataset  in  8  dataset index of request
- job_ready  out  1  job accepted when job_valid & job_ready
- dataset  out  8  latched index, drives upper address bits of input/output memories
- enc_start  out  1  start to encode_rp
- enc_done  in  1  done from encode_rp
- cd_rd_addr  out  OUT_DEPTH  output-RAM read address
- cd_rd_data  in  OUT_D_SIZE  output-RAM read data, one-cycle registered latency
- out_valid  out  1  stream word valid
- out_data  out  OUT_D_SIZE  stream word
- out_last  out  1  marks word OUT_LEN-1
- out_ready  in  1  downstream ready
- busy  out  1  high in any state but IDLE
- err  out  1  sticky watchdog error

Function
REQ-003 SHALL implement FSM IDLE -> START -> RUN -> DRAIN -> IDLE, plus ERR when timeout is compiled in.
REQ-004 IDLE: job_ready=1; on handshake latch job_dataset into dataset, clear err, go START.
REQ-005 START: enc_start=1 for exactly START_HOLD cycles, then RUN; enc_done ignored in START.
REQ-006 RUN: enc_start=0; first cycle with enc_done=1 goes DRAIN with cd_rd_addr=0.
REQ-007 DRAIN: read issued (cd_rd_addr advanced) only when skid occupancy plus in-flight reads < 2; word at address k appears in skid one cycle after issue.
REQ-008 Stream: out_data/out_valid from skid head; word popped on out_valid & out_ready; order preserved; no drop or duplicate under any out_ready pattern.
REQ-009 out_last=1 only with word OUT_LEN-1; cd_rd_addr saturates at OUT_LEN-1, never wraps; DRAIN -> IDLE the cycle after out_last popped.
REQ-010 Full throughput: out_ready held 1 gives one word per cycle after 2-cycle initial latency from DRAIN entry.
REQ-011 job_ready=0 in START, RUN, DRAIN; job_valid there is ignored and not queued.
REQ-012 dataset stable from acceptance until return to IDLE.

Reset
REQ-013 rst_n low SHALL asynchronously force IDLE, enc_start=0, out_valid=0, out_last=0, busy=0, err=0, cd_rd_addr=0, dataset=0, skid empty, counters 0; applies mid-job (job abandoned).
REQ-014 Release SHALL be synchronous-safe: first handshake accepted no earlier than first rising edge after rst_n high.

Configuration
REQ-015 Macro ENCODE_CTRL_TIMEOUT_EN: when defined, RUN counts cycles; reaching TIMEOUT_CYC without enc_done goes ERR, err=1, job_ready=1 in ERR, next handshake leaves ERR as in IDLE; when undefined, no counter/ERR state exists, err tied 0, RUN waits indefinitely.

Structure
REQ-016 Package encode_ctrl_pkg SHALL hold FSM state encoding, skid depth constant (2) and dataset width (8).
REQ-017 Sub-module encode_ctrl_skid SHALL implement the 2-entry buffer (push, pop, count, head data).

Verification
REQ-018 Scenarios:
- job_dataset=3, enc_done after 100 cycles, out_ready=1 -> enc_start high 6 cycles, OUT_LEN words addresses 0..OUT_LEN-1 in order, out_last on final, busy low next cycle.
- out_ready toggled 1010..., and held 0 for 50 cycles mid-stream -> identical word sequence, count exactly OUT_LEN, cd_rd_addr frozen during stall.
- job_valid held high through a job -> exactly one acceptance per job, dataset unchanged until IDLE.
- enc_done pulsed during START -> ignored, FSM waits for later enc_done in RUN.
- rst_n low at word 200 of DRAIN -> all outputs reset values immediately, next job restarts at address 0.
- ENCODE_CTRL_TIMEOUT_EN, TIMEOUT_CYC=1000, no enc_done -> err=1 at cycle 1000 of RUN, job_ready=1, new job clears err.
